// File: rtl/qtr_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// qtr_sequencer_pkg : state encoding and default timing for the QTR sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
package qtr_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EMIT    = 3'd1,
    ST_CHARGE  = 3'd2,
    ST_MEASURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  localparam int c_tick_div_dflt     = 50;
  localparam int c_emit_ticks_dflt   = 200;
  localparam int c_charge_ticks_dflt = 10;
  localparam int c_max_count_dflt    = 255;
  localparam int c_cnt_w             = 8;

endpackage
`default_nettype wire

// File: rtl/qtr_channel_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// qtr_channel_timer : per-channel input synchronizer and saturating decay counter
// Revision: 1.0
// ---------------------------------------------------------------------------
module qtr_channel_timer
  import qtr_sequencer_pkg::*;
#(
  parameter int MAX_COUNT = c_max_count_dflt
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_i,
  input  logic               clear_i,
  input  logic               tick_i,
  input  logic               measure_i,
  output logic [c_cnt_w-1:0] count_o,
  output logic               done_o
);

  localparam logic [c_cnt_w-1:0] c_max = c_cnt_w'(MAX_COUNT);

  logic [1:0]         sync_q;
  logic [c_cnt_w-1:0] count_q;
  logic [c_cnt_w-1:0] count_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b00;
      count_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], in_i};
      count_q <= count_d;
    end
  end

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (measure_i && tick_i && sync_q[1] && (count_q != c_max)) begin
      count_d = count_q + c_cnt_w'(1);
    end
  end

  // Done looks at the post-tick count so a timeout ends MEASURE on the final tick.
  assign done_o  = ~sync_q[1] | (count_d == c_max);
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/qtr_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// qtr_sequencer : emit/charge/release/measure cycle for two QTR reflectance channels
// Revision: 1.0
// ---------------------------------------------------------------------------
module qtr_sequencer
  import qtr_sequencer_pkg::*;
#(
  parameter int TICK_DIV     = c_tick_div_dflt,
  parameter int EMIT_TICKS   = c_emit_ticks_dflt,
  parameter int CHARGE_TICKS = c_charge_ticks_dflt,
  parameter int MAX_COUNT    = c_max_count_dflt
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [1:0]  qtr_ctrl,
  output logic [1:0]  qtr_out_en,
  output logic [1:0]  qtr_out_sig,
  input  logic [1:0]  qtr_in_sig,
  output logic [15:0] qtr_value,
  output logic        qtr_valid,
  output logic        busy
);

  localparam int c_pw = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_e                      state_q;
  state_e                      state_d;
  logic [c_pw-1:0]             presc_q;
  logic [c_pw-1:0]             presc_d;
  logic [15:0]                 tick_cnt_q;
  logic [15:0]                 tick_cnt_d;
  logic [15:0]                 value_q;
  logic                        w_tick;
  logic [1:0]                  w_done;
  logic [1:0][c_cnt_w-1:0]     w_count;

  assign w_tick = (presc_q == c_pw'(TICK_DIV - 1));

  for (genvar i = 0; i < 2; i++) begin : g_chan
    qtr_channel_timer #(
      .MAX_COUNT (MAX_COUNT)
    ) u_timer (
      .clk       (clk),
      .reset     (reset),
      .in_i      (qtr_in_sig[i]),
      .clear_i   (state_q == ST_CHARGE),
      .tick_i    (w_tick),
      .measure_i (state_q == ST_MEASURE),
      .count_o   (w_count[i]),
      .done_o    (w_done[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      tick_cnt_q <= '0;
      value_q    <= '0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      tick_cnt_q <= tick_cnt_d;
      if (state_q == ST_DONE) begin
        value_q <= {w_count[1], w_count[0]};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (en) state_d = ST_EMIT;
      ST_EMIT:    if (w_tick && (tick_cnt_q == 16'(EMIT_TICKS - 1))) state_d = ST_CHARGE;
      ST_CHARGE:  if (w_tick && (tick_cnt_q == 16'(CHARGE_TICKS - 1))) state_d = ST_MEASURE;
      ST_MEASURE: if (&w_done) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Prescaler and phase tick count restart on every state entry.
  always_comb begin
    presc_d    = w_tick ? '0 : presc_q + c_pw'(1);
    tick_cnt_d = w_tick ? tick_cnt_q + 16'd1 : tick_cnt_q;
    if (state_d != state_q) begin
      presc_d    = '0;
      tick_cnt_d = '0;
    end
  end

  always_comb begin
    qtr_ctrl    = 2'b00;
    qtr_out_en  = 2'b00;
    qtr_out_sig = 2'b00;
    case (state_q)
      ST_EMIT, ST_MEASURE: qtr_ctrl = 2'b11;
      ST_CHARGE: begin
        qtr_ctrl    = 2'b11;
        qtr_out_en  = 2'b11;
        qtr_out_sig = 2'b11;
      end
      default: ;
    endcase
  end

  // The result is visible on the valid cycle itself, then held in value_q.
  assign qtr_value = (state_q == ST_DONE) ? {w_count[1], w_count[0]} : value_q;
  assign qtr_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_qtr_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_qtr_sequencer : directed self-checking bench for qtr_sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_qtr_sequencer;

  localparam int TICK_DIV     = 4;
  localparam int EMIT_TICKS   = 2;
  localparam int CHARGE_TICKS = 3;
  localparam int MAX_COUNT    = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [1:0]  qtr_in_sig;
  logic [1:0]  qtr_ctrl;
  logic [1:0]  qtr_out_en;
  logic [1:0]  qtr_out_sig;
  logic [15:0] qtr_value;
  logic        qtr_valid;
  logic        busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  qtr_sequencer #(
    .TICK_DIV     (TICK_DIV),
    .EMIT_TICKS   (EMIT_TICKS),
    .CHARGE_TICKS (CHARGE_TICKS),
    .MAX_COUNT    (MAX_COUNT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .qtr_ctrl    (qtr_ctrl),
    .qtr_out_en  (qtr_out_en),
    .qtr_out_sig (qtr_out_sig),
    .qtr_in_sig  (qtr_in_sig),
    .qtr_value   (qtr_value),
    .qtr_valid   (qtr_valid),
    .busy        (busy)
  );

  // Returns at the negedge of the first MEASURE cycle.
  task automatic wait_measure_entry(output bit ok);
    int n = 0;
    while (qtr_out_en != 2'b11 && n < 500) begin @(negedge clk); n++; end
    while (qtr_out_en == 2'b11 && n < 500) begin @(negedge clk); n++; end
    ok = (n < 500);
  endtask

  task automatic test_reset;
    int cnt;
    reset = 1'b1; en = 1'b1; qtr_in_sig = 2'b11;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({qtr_ctrl, qtr_out_en, qtr_out_sig} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_pads: got %b expected 000000", {qtr_ctrl, qtr_out_en, qtr_out_sig});
    end
    tests_run++;
    if ({qtr_value, qtr_valid, busy} !== 18'b0) begin
      tests_failed++;
      $display("FAIL reset_value: got %h expected 0", {qtr_value, qtr_valid, busy});
    end
    reset = 1'b0;
    @(negedge clk);
    tests_run++;
    if (qtr_ctrl !== 2'b11) begin
      tests_failed++;
      $display("FAIL release_ctrl: got %b expected 11", qtr_ctrl);
    end
    cnt = 1;
    while (qtr_ctrl == 2'b11 && qtr_out_en == 2'b00 && cnt < 100) begin @(negedge clk); cnt++; end
    cnt--;
    tests_run++;
    if (cnt != EMIT_TICKS * TICK_DIV) begin
      tests_failed++;
      $display("FAIL emit_len: got %0d expected %0d", cnt, EMIT_TICKS * TICK_DIV);
    end
    tests_run++;
    if (qtr_out_sig !== 2'b11 || qtr_ctrl !== 2'b11) begin
      tests_failed++;
      $display("FAIL charge_drive: got sig=%b ctrl=%b expected 11/11", qtr_out_sig, qtr_ctrl);
    end
    cnt = 0;
    while (qtr_out_en == 2'b11 && cnt < 100) begin @(negedge clk); cnt++; end
    tests_run++;
    if (cnt != CHARGE_TICKS * TICK_DIV) begin
      tests_failed++;
      $display("FAIL charge_len: got %0d expected %0d", cnt, CHARGE_TICKS * TICK_DIV);
    end
  endtask

  // Entered at the negedge of the first MEASURE cycle with inputs held high.
  task automatic test_timeout;
    int meas = 1;
    while (meas < 2000) begin
      @(negedge clk);
      if (qtr_ctrl == 2'b11 && qtr_out_en == 2'b00) meas++;
      else break;
    end
    tests_run++;
    if (meas != MAX_COUNT * TICK_DIV) begin
      tests_failed++;
      $display("FAIL timeout_len: got %0d expected %0d", meas, MAX_COUNT * TICK_DIV);
    end
    tests_run++;
    if (qtr_valid !== 1'b1 || qtr_value !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL timeout_value: got valid=%b value=%h expected 1/ffff", qtr_valid, qtr_value);
    end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || qtr_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_gap: got busy=%b valid=%b expected 0/0", busy, qtr_valid);
    end
    @(negedge clk);
    tests_run++;
    if (qtr_ctrl !== 2'b11) begin
      tests_failed++;
      $display("FAIL back_to_back: got ctrl=%b expected 11", qtr_ctrl);
    end
  endtask

  task automatic test_nominal;
    bit ok;
    int c;
    wait_measure_entry(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL nominal_entry: got timeout expected MEASURE entry");
    end
    c = 0;
    while (!qtr_valid && c < 400) begin
      @(negedge clk); c++;
      if (c == 80)  qtr_in_sig[0] = 1'b0;
      if (c == 160) qtr_in_sig[1] = 1'b0;
    end
    tests_run++;
    if (qtr_valid !== 1'b1 || qtr_value !== 16'h2814) begin
      tests_failed++;
      $display("FAIL nominal_value: got valid=%b value=%h expected 1/2814", qtr_valid, qtr_value);
    end
    qtr_in_sig = 2'b11;
    @(negedge clk);
    tests_run++;
    if (qtr_valid !== 1'b0 || qtr_value !== 16'h2814) begin
      tests_failed++;
      $display("FAIL nominal_hold: got valid=%b value=%h expected 0/2814", qtr_valid, qtr_value);
    end
  endtask

  task automatic test_reset_mid_charge;
    int n = 0;
    int cnt;
    while (qtr_out_en != 2'b11 && n < 500) begin @(negedge clk); n++; end
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    tests_run++;
    if (qtr_out_en !== 2'b00 || qtr_value !== 16'h0000 || qtr_ctrl !== 2'b00 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got oe=%b value=%h ctrl=%b busy=%b expected 00/0000/00/0",
               qtr_out_en, qtr_value, qtr_ctrl, busy);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    cnt = 1;
    while (qtr_ctrl == 2'b11 && qtr_out_en == 2'b00 && cnt < 100) begin @(negedge clk); cnt++; end
    cnt--;
    tests_run++;
    if (cnt != EMIT_TICKS * TICK_DIV || qtr_out_en !== 2'b11) begin
      tests_failed++;
      $display("FAIL restart_emit: got %0d oe=%b expected %0d/11", cnt, qtr_out_en, EMIT_TICKS * TICK_DIV);
    end
  endtask

  // Entered at the first CHARGE cycle.
  task automatic test_immediate_low;
    int n = 0;
    int meas = 1;
    qtr_in_sig = 2'b00;
    while (qtr_out_en == 2'b11 && n < 100) begin @(negedge clk); n++; end
    while (meas < 2000) begin
      @(negedge clk);
      if (qtr_ctrl == 2'b11 && qtr_out_en == 2'b00) meas++;
      else break;
    end
    tests_run++;
    if (meas != 1 || qtr_valid !== 1'b1 || qtr_value !== 16'h0000) begin
      tests_failed++;
      $display("FAIL immediate_low: got len=%0d valid=%b value=%h expected 1/1/0000", meas, qtr_valid, qtr_value);
    end
    qtr_in_sig = 2'b11;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (qtr_ctrl !== 2'b11 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL immediate_next: got ctrl=%b busy=%b expected 11/1", qtr_ctrl, busy);
    end
  endtask

  task automatic test_en_drop;
    bit ok;
    bit bad = 1'b0;
    int c;
    wait_measure_entry(ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL en_drop_entry: got timeout expected MEASURE entry");
    end
    c = 0;
    while (!qtr_valid && c < 400) begin
      @(negedge clk); c++;
      if (c == 10) en = 1'b0;
      if (c == 20) qtr_in_sig = 2'b00;
    end
    tests_run++;
    if (qtr_valid !== 1'b1 || qtr_value !== 16'h0505) begin
      tests_failed++;
      $display("FAIL en_drop_value: got valid=%b value=%h expected 1/0505", qtr_valid, qtr_value);
    end
    qtr_in_sig = 2'b11;
    repeat (100) begin
      @(negedge clk);
      if (qtr_ctrl !== 2'b00 || busy !== 1'b0 || qtr_valid !== 1'b0) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL en_drop_idle: got activity after en low expected quiet IDLE");
    end
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0;
    qtr_in_sig = 2'b11;
    test_reset;
    test_timeout;
    test_nominal;
    test_reset_mid_charge;
    test_immediate_low;
    test_en_drop;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
